// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // One fetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Sequential successor of a PC; wraps silently at the top of the address space.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with push, pop, flush and occupancy count.
// Latency: an entry pushed at an edge is visible at the head right after that edge.
// Backpressure: caller must only push when not full or popping in the same cycle; flush wins over both.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_dat,
  input  logic                     pop,
  output fetch_entry_t             head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t        mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;

  // Storage holds no control meaning, so it is written without reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers and count: reset/flush empty the buffer; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head always shows the slot at the read pointer, so it stays stable while nothing pops.
  always_comb begin
    head_dat = mem[rd_ptr];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads instruction memory and queues {instr, pc} for decode.
// Latency: 1 cycle from PC presented on imaddr_o to the entry at the head of an empty buffer.
// Backpressure: valid/ready to decode; fetch stalls (PC holds) when the buffer is full and not draining.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2   // 2 or 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imaddr_o,
  input  logic [XLEN-1:0] instr_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_instr_o,
  output logic [XLEN-1:0] out_pc_o,
  output logic [XLEN-1:0] out_pcplus4_o,
  output logic            fault_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q;
  logic            fault_q;
  logic            redirect_take;
  logic            redirect_misaligned;
  logic            pop;
  logic            push;
  logic [CW-1:0]   count;
  fetch_entry_t    push_dat;
  fetch_entry_t    head_dat;

  // Control: a redirect is honoured only while no fault is latched and then blocks push/pop.
  always_comb begin
    redirect_take       = redirect_valid_i && !fault_q;
    redirect_misaligned = (redirect_pc_i[1:0] != 2'b00);
    pop                 = out_valid_o && out_ready_i && !redirect_take;
    push                = !fault_q && !redirect_take && ((count < CW'(DEPTH)) || pop);
    push_dat.instr      = instr_i;
    push_dat.pc         = pc_q;
  end

  // PC register: reset, aligned redirect, or advance on every push; otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_take) begin
      if (!redirect_misaligned) pc_q <= redirect_pc_i;
    end else if (push) begin
      pc_q <= pc_plus4(pc_q);
    end
  end

  // Sticky fault on a misaligned redirect; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (redirect_take && redirect_misaligned) begin
      fault_q <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_take),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count)
  );

  // Outputs: imaddr comes straight from the PC flop, so ready/redirect never reach it combinationally.
  always_comb begin
    imaddr_o      = pc_q;
    fault_o       = fault_q;
    out_valid_o   = (count != '0);
    out_instr_o   = head_dat.instr;
    out_pc_o      = head_dat.pc;
    out_pcplus4_o = pc_plus4(head_dat.pc);
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imaddr_o;
  logic [31:0] instr_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_o;
  logic [31:0] out_pcplus4_o;
  logic        fault_o;

  int checks = 0;
  int passes = 0;

  // Reference state: queued entries, PC and fault flag.
  logic [31:0] mq_pc[$];
  logic [31:0] mq_in[$];
  logic [31:0] mpc;
  logic        mfault;

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a_0f0f;
  endfunction

  assign instr_i = imem(imaddr_o);

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imaddr_o         (imaddr_o),
    .instr_i          (instr_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_instr_o      (out_instr_o),
    .out_pc_o         (out_pc_o),
    .out_pcplus4_o    (out_pcplus4_o),
    .fault_o          (fault_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic compare_all();
    check("valid", {31'b0, out_valid_o}, {31'b0, mq_pc.size() != 0});
    check("imaddr", imaddr_o, mpc);
    check("fault", {31'b0, fault_o}, {31'b0, mfault});
    if (mq_pc.size() != 0) begin
      check("out_pc", out_pc_o, mq_pc[0]);
      check("out_instr", out_instr_o, mq_in[0]);
      check("out_pcplus4", out_pcplus4_o, mq_pc[0] + 32'd4);
    end
  endtask

  // Apply one cycle of inputs, advance the reference model by the fetch rules, then compare.
  task automatic step(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic do_pop;
    logic do_push;
    rst_n            = rst;
    redirect_valid_i = rv;
    redirect_pc_i    = rpc;
    out_ready_i      = rdy;
    if (!rst) begin
      mq_pc.delete();
      mq_in.delete();
      mpc    = RESET_PC;
      mfault = 1'b0;
    end else if (rv && !mfault) begin
      mq_pc.delete();
      mq_in.delete();
      if (rpc[1:0] == 2'b00) mpc = rpc;
      else mfault = 1'b1;
    end else begin
      do_pop  = (mq_pc.size() != 0) && rdy;
      do_push = !mfault && ((mq_pc.size() < DEPTH) || do_pop);
      if (do_pop) begin
        void'(mq_pc.pop_front());
        void'(mq_in.pop_front());
      end
      if (do_push) begin
        mq_pc.push_back(mpc);
        mq_in.push_back(imem(mpc));
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] rpc;
    mpc    = RESET_PC;
    mfault = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_4000, 1'b1);
    check("rst_valid", {31'b0, out_valid_o}, 32'd0);
    check("rst_imaddr", imaddr_o, 32'h0000_3000);

    // Streaming with ready high: consecutive PCs, valid from the first cycle
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("stream0", out_pc_o, 32'h0000_3000);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("stream1", out_pc_o, 32'h0000_3004);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("stream2", out_pc_o, 32'h0000_3008);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("stream3", out_pc_o, 32'h0000_300c);

    // Stall after reset: buffer fills and fetch holds
    step(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    check("stall_imaddr", imaddr_o, 32'h0000_3008);
    check("stall_head", out_pc_o, 32'h0000_3000);
    check("stall_valid", {31'b0, out_valid_o}, 32'd1);

    // Redirect while full flushes and retargets
    step(1'b1, 1'b1, 32'h0000_3100, 1'b0);
    check("redir_valid", {31'b0, out_valid_o}, 32'd0);
    check("redir_imaddr", imaddr_o, 32'h0000_3100);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("redir_head", out_pc_o, 32'h0000_3100);

    // Wrap at the top of the address space
    step(1'b1, 1'b1, 32'hffff_fffc, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("wrap_pc0", out_pc_o, 32'hffff_fffc);
    check("wrap_plus4", out_pcplus4_o, 32'h0000_0000);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("wrap_pc1", out_pc_o, 32'h0000_0000);

    // Misaligned redirect: sticky fault, empty buffer, PC held, later redirects ignored
    held = imaddr_o;
    step(1'b1, 1'b1, 32'h0000_3102, 1'b1);
    check("fault_set", {31'b0, fault_o}, 32'd1);
    check("fault_imaddr", imaddr_o, held);
    for (int i = 0; i < 3; i++) step(1'b1, 1'(i == 1), 32'h0000_5000, 1'b1);
    check("fault_novalid", {31'b0, out_valid_o}, 32'd0);
    check("fault_pc_held", imaddr_o, held);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("fault_clear", {31'b0, fault_o}, 32'd0);

    // Reset coincident with redirect and pop
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_3100, 1'b1);
    check("rstpri_imaddr", imaddr_o, 32'h0000_3000);
    check("rstpri_valid", {31'b0, out_valid_o}, 32'd0);
    check("rstpri_fault", {31'b0, fault_o}, 32'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) rpc = 32'hffff_fff8;
      step(1'($urandom_range(0, 63) != 0),
           1'($urandom_range(0, 7) == 0),
           rpc,
           1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
